// File: rtl/atvp002_pkg.sv
// ---------------------------------------------------------------------------
// atvp002_pkg
// Shared definitions for the two-switch appliance selector:
//   - switch code constants ({A,B} after synchronisation)
//   - FSM state type and state constants (encoded identically to the codes)
//   - debounce counter width helper
// ---------------------------------------------------------------------------
package atvp002_pkg;

  // Switch codes, MSB = A, LSB = B
  localparam logic [1:0] CODE_OFF = 2'b00;
  localparam logic [1:0] CODE_TV  = 2'b01;
  localparam logic [1:0] CODE_AL  = 2'b11;
  localparam logic [1:0] CODE_PC  = 2'b10;

  // FSM states; encoding matches the code that selects each state
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_TV_ON = 2'b01;
  localparam state_t ST_ALARM = 2'b11;
  localparam state_t ST_PC_ON = 2'b10;

  // Width needed to hold a count from 0 up to and including 'stable'
  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/atvp002_if.sv
// ---------------------------------------------------------------------------
// atvp002_if
// Front-panel switch / load-enable bundle.
//   A, B        : raw asynchronous switch levels (A = code MSB)
//   TV, PC, AL  : registered one-hot load enables
// Modports:
//   master : panel side, drives switches and observes enables
//   slave  : controller side, reads switches and drives enables
// ---------------------------------------------------------------------------
interface atvp002_if;

  logic A;
  logic B;
  logic TV;
  logic PC;
  logic AL;

  modport master (output A, output B, input TV, input PC, input AL);
  modport slave  (input A, input B, output TV, output PC, output AL);

endinterface

// File: rtl/atvp002_debounce.sv
// ---------------------------------------------------------------------------
// atvp002_debounce
// Synchroniser chain plus stability counter for an N-bit bus.
// A new value is accepted only after STABLE_CYCLES consecutive identical
// synchronised samples; shorter glitches never reach code_acc.
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   synchronous active-high reset
//   din      in   asynchronous input bus
//   code_acc out  last accepted (debounced) value
// ---------------------------------------------------------------------------
module atvp002_debounce
  import atvp002_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] code_acc
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] code_s;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;

  assign code_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: each bit passes SYNC_STAGES flops before any logic
  // looks at it, so metastability settles before the comparator below.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Stability tracking: any change restarts the count at 1 with the new
  // candidate. The count saturates at STABLE_CYCLES, and the accepted value
  // is updated on the very edge the count reaches that limit. With
  // STABLE_CYCLES == 1 this is the load edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      code_acc <= '0;
    end else if (code_s != cand_q) begin
      cand_q <= code_s;
      cnt_q  <= CNT_ONE;
      if (STABLE_CYCLES == 1) begin
        code_acc <= code_s;
      end
    end else if (cnt_q < STABLE_CNT) begin
      cnt_q <= cnt_q + CNT_ONE;
      if (cnt_q == STABLE_CNT - CNT_ONE) begin
        code_acc <= cand_q;
      end
    end
  end

endmodule

// File: rtl/atvp002_ctrl.sv
// ---------------------------------------------------------------------------
// atvp002_ctrl
// Two-switch appliance selector. Synchronises and debounces switches A/B,
// decodes the accepted code in a small FSM and drives registered one-hot
// enables TV / PC / AL (all zero in IDLE).
// Ports:
//   clk  in   system clock (rising edge)
//   rst  in   synchronous active-high reset
//   bus  slave modport of atvp002_if (A, B in; TV, PC, AL out)
// Parameters:
//   SYNC_STAGES    synchroniser depth (>= 2)
//   STABLE_CYCLES  equal samples required to accept a code (>= 1)
// Build option:
//   ATVP002_ALARM_LATCH_EN  when defined, ALARM holds for every accepted code
//                           except 00, which returns to IDLE.
// Latency from a stable input change to the outputs is
// SYNC_STAGES + STABLE_CYCLES + 1 rising edges.
// ---------------------------------------------------------------------------
module atvp002_ctrl
  import atvp002_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst,
  atvp002_if.slave  bus
);

  logic [1:0] code_acc;
  state_t     state_q;
  state_t     next_state;
  logic       tv_q;
  logic       pc_q;
  logic       al_q;

  atvp002_debounce #(
    .WIDTH         (2),
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .din      ({bus.A, bus.B}),
    .code_acc (code_acc)
  );

  // Next-state decode: every accepted code maps straight to its state, so
  // any state can reach any other in one step. With the alarm latch built
  // in, ALARM only yields to an accepted 00.
  always_comb begin
    next_state = state_q;
    case (code_acc)
      CODE_OFF: next_state = ST_IDLE;
      CODE_TV:  next_state = ST_TV_ON;
      CODE_PC:  next_state = ST_PC_ON;
      default:  next_state = ST_ALARM;
    endcase
`ifdef ATVP002_ALARM_LATCH_EN
    if (state_q == ST_ALARM && code_acc != CODE_OFF) begin
      next_state = ST_ALARM;
    end
`else
`endif
  end

  // State and output registers update together from next_state, so the
  // enables change on the same edge as the state and are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tv_q    <= 1'b0;
      pc_q    <= 1'b0;
      al_q    <= 1'b0;
    end else begin
      state_q <= next_state;
      tv_q    <= (next_state == ST_TV_ON);
      pc_q    <= (next_state == ST_PC_ON);
      al_q    <= (next_state == ST_ALARM);
    end
  end

  assign bus.TV = tv_q;
  assign bus.PC = pc_q;
  assign bus.AL = al_q;

endmodule

// File: tb/tb_atvp002_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atvp002_ctrl
// Directed self-checking bench for atvp002_ctrl with default parameters.
// Expected enables are written as {TV, PC, AL}.
// ---------------------------------------------------------------------------
module tb_atvp002_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  atvp002_if bus ();

  atvp002_ctrl #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 ns past it before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive new switch levels (called 1 ns after an edge)
  task automatic applyStimulus(input logic a, input logic b);
    bus.A = a;
    bus.B = b;
  endtask

  // Compare enables with expectation and confirm at most one is high
  task automatic checkOutput(input string tag, input logic [2:0] exp_out);
    logic [2:0] obs;
    obs = {bus.TV, bus.PC, bus.AL};
    checks++;
    assert (obs === exp_out)
    else begin
      failures++;
      $display("[TB] FAIL %s enables observed=%b expected=%b at %0t", tag, obs, exp_out, $time);
      $error("[TB] %s enables observed=%b expected=%b", tag, obs, exp_out);
    end
    checks++;
    assert ($countones(obs) <= 1)
    else begin
      failures++;
      $display("[TB] FAIL %s_onehot enables observed=%b expected at most one high", tag, obs);
      $error("[TB] %s_onehot enables observed=%b", tag, obs);
    end
  endtask

  // Apply a code and hold it 30 cycles: edges 1..6 keep the old value,
  // edge 7 onward shows the new one
  task automatic runPhase(input string tag, input logic a, input logic b,
                          input logic [2:0] prev_out, input logic [2:0] new_out);
    applyStimulus(a, b);
    for (int i = 1; i <= 30; i++) begin
      step();
      checkOutput(tag, (i < 7) ? prev_out : new_out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Reset held for 3 cycles with switches off
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("reset", 3'b000);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("post_reset", 3'b000);
    end

    // 01 -> TV, 11 -> ALARM
    runPhase("code_tv", 1'b0, 1'b1, 3'b000, 3'b100);
    runPhase("code_al", 1'b1, 1'b1, 3'b100, 3'b001);

`ifdef ATVP002_ALARM_LATCH_EN
    runPhase("code_pc", 1'b1, 1'b0, 3'b001, 3'b001);
    runPhase("code_off", 1'b0, 1'b0, 3'b001, 3'b000);
`else
    runPhase("code_pc", 1'b1, 1'b0, 3'b001, 3'b010);
    runPhase("code_off", 1'b0, 1'b0, 3'b010, 3'b000);
`endif

    // Two-cycle glitch on B must never be accepted
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput("glitch", 3'b000);
    step();
    checkOutput("glitch", 3'b000);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 28; i++) begin
      step();
      checkOutput("glitch", 3'b000);
    end

    // Reset two edges into a change to 01; inputs return to 00
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput("mid_reset_pre", 3'b000);
    step();
    checkOutput("mid_reset_pre", 3'b000);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    step();
    checkOutput("mid_reset", 3'b000);
    step();
    checkOutput("mid_reset", 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      checkOutput("mid_reset_post", 3'b000);
    end

    // Fresh code after the aborted one still works
    runPhase("code_tv_again", 1'b0, 1'b1, 3'b000, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
